// File: rtl/custom_axi_ip_pkg.sv
// Shared types and constants for the custom IP core register interface.
package custom_axi_ip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } status_e;

  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [3:0] CTRL_OFS    = 4'h0;
  localparam logic [3:0] DATA_IN_OFS = 4'h4;
  localparam logic [3:0] RESULT_OFS  = 4'h8;
  localparam logic [3:0] STATUS_OFS  = 4'hC;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT   = 1;

  localparam int unsigned ST_LIVE_LSB = 0;
  localparam int unsigned ST_LIVE_W   = 2;
  localparam int unsigned ST_DONE_BIT = 2;
  localparam int unsigned ST_REJ_BIT  = 3;
  localparam int unsigned ST_CNT_LSB  = 8;
  localparam int unsigned ST_CNT_W    = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
  } w_beat_t;

endpackage

// File: rtl/custom_axi_ip_axil_slv.sv
// AXI4-Lite slave channel handling: AW/W holding slots, B and R response
// registers, and a simple one-cycle write/read strobe interface.
module custom_axi_ip_axil_slv
  import custom_axi_ip_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [AXI_DATA_W-1:0] s_wdata,
  input  logic [AXI_STRB_W-1:0] s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [AXI_DATA_W-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [AXI_DATA_W-1:0] wr_data_o,
  output logic [AXI_STRB_W-1:0] wr_strb_o,
  input  logic [1:0]            wr_resp_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [AXI_DATA_W-1:0] rd_data_i,
  input  logic [1:0]            rd_resp_i
);

  logic                  live_q;
  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_full_q, w_full_d;
  w_beat_t               w_beat_q, w_beat_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  aw_hs, w_hs;

  // live_q keeps every ready low for the first cycle after reset
  assign s_awready = live_q & ~aw_full_q & ~bvalid_q;
  assign s_wready  = live_q & ~w_full_q & ~bvalid_q;
  assign s_arready = live_q & ~rvalid_q;
  assign aw_hs     = s_awvalid & s_awready;
  assign w_hs      = s_wvalid & s_wready;

  assign wr_en_o   = aw_full_q & w_full_q;
  assign wr_addr_o = aw_addr_q;
  assign wr_data_o = w_beat_q.data;
  assign wr_strb_o = w_beat_q.strb;
  assign rd_en_o   = s_arvalid & s_arready;
  assign rd_addr_o = s_araddr;

  assign s_bvalid = bvalid_q;
  assign s_bresp  = bresp_q;
  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_beat_d  = w_beat_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_awaddr;
    end
    if (w_hs) begin
      w_full_d      = 1'b1;
      w_beat_d.data = s_wdata;
      w_beat_d.strb = s_wstrb;
    end
    // commit empties both slots; the B response blocks refilling until it drains
    if (wr_en_o) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_resp_i;
    end
    if (bvalid_q && s_bready) begin
      bvalid_d = 1'b0;
    end
    if (rd_en_o) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data_i;
      rresp_d  = rd_resp_i;
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      live_q    <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_beat_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      live_q    <= 1'b1;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_beat_q  <= w_beat_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: rtl/custom_axi_ip_regif.sv
// Register file between the AXI4-Lite bus and the custom IP core:
// DATA_IN/START toward the core, RESULT/STATUS captured back from it.
module custom_axi_ip_regif
  import custom_axi_ip_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [DATA_WIDTH-1:0]   ipreg_data,
  output logic                    enable_in,
  input  logic [DATA_WIDTH-1:0]   ipreg_data_out,
  input  status_e                 status_in
);

  logic                  wr_en, rd_en;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [AXI_DATA_W-1:0] wr_data, rd_data_c;
  logic [AXI_STRB_W-1:0] wr_strb;
  logic [1:0]            wr_resp_c, rd_resp_c;
  logic [3:0]            wr_ofs, rd_ofs;
  logic                  wr_mapped, rd_mapped;
  logic                  start_c, clr_c;
  logic [AXI_DATA_W-1:0] status_word;
  logic                  unused_c;

  logic [AXI_DATA_W-1:0] data_in_q, data_in_d;
  logic [AXI_DATA_W-1:0] result_q, result_d;
  logic                  done_q, done_d;
  logic                  rej_q, rej_d;
  logic [ST_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  enable_q, enable_d;
  logic                  pend_q, pend_d;

  custom_axi_ip_axil_slv #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_slv (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb),
    .wr_resp_i (wr_resp_c),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data_c),
    .rd_resp_i (rd_resp_c)
  );

  assign wr_ofs    = {wr_addr[3:2], 2'b00};
  assign rd_ofs    = {rd_addr[3:2], 2'b00};
  assign wr_mapped = ~|wr_addr[ADDR_WIDTH-1:4];
  assign rd_mapped = ~|rd_addr[ADDR_WIDTH-1:4];
  assign unused_c  = ^{wr_addr[1:0], rd_addr[1:0]};

  assign ipreg_data = data_in_q;
  assign enable_in  = enable_q;

  always_comb begin
    status_word = '0;
    status_word[ST_LIVE_LSB +: ST_LIVE_W] = status_in;
    status_word[ST_DONE_BIT]              = done_q;
    status_word[ST_REJ_BIT]               = rej_q;
    status_word[ST_CNT_LSB +: ST_CNT_W]   = cnt_q;
  end

  // Read mux samples current register values; updates land a cycle later
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_SLVERR;
    if (rd_mapped) begin
      rd_resp_c = RESP_OKAY;
      case (rd_ofs)
        DATA_IN_OFS: rd_data_c = data_in_q;
        RESULT_OFS:  rd_data_c = result_q;
        STATUS_OFS:  rd_data_c = status_word;
        default:     rd_data_c = '0;
      endcase
    end
  end

  always_comb begin
    data_in_d = data_in_q;
    result_d  = result_q;
    done_d    = done_q;
    rej_d     = rej_q;
    cnt_d     = cnt_q;
    enable_d  = 1'b0;
    pend_d    = pend_q;
    start_c   = 1'b0;
    clr_c     = 1'b0;
    wr_resp_c = RESP_SLVERR;
    if (wr_mapped && (wr_ofs == CTRL_OFS || wr_ofs == DATA_IN_OFS)) begin
      wr_resp_c = RESP_OKAY;
    end
    // a pulse stays outstanding until the core is seen leaving IDLE
    if (status_in != IDLE) begin
      pend_d = 1'b0;
    end
    if (wr_en && wr_resp_c == RESP_OKAY) begin
      if (wr_ofs == DATA_IN_OFS) begin
        for (int unsigned b = 0; b < AXI_STRB_W; b++) begin
          if (wr_strb[b]) begin
            data_in_d[b*8 +: 8] = wr_data[b*8 +: 8];
          end
        end
      end else begin
        start_c = wr_strb[0] & wr_data[CTRL_START_BIT];
        clr_c   = wr_strb[0] & wr_data[CTRL_CLR_BIT];
      end
    end
    if (clr_c) begin
      done_d = 1'b0;
      rej_d  = 1'b0;
      cnt_d  = '0;
    end
    if (start_c) begin
      if (status_in == IDLE && !pend_q) begin
        enable_d = 1'b1;
        pend_d   = 1'b1;
      end else begin
        rej_d = 1'b1;
      end
    end
    // capture is applied after CLR so it wins in a same-cycle collision
    if (status_in == DONE) begin
      result_d = ipreg_data_out;
      done_d   = 1'b1;
      cnt_d    = cnt_d + ST_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_in_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      rej_q     <= 1'b0;
      cnt_q     <= '0;
      enable_q  <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      data_in_q <= data_in_d;
      result_q  <= result_d;
      done_q    <= done_d;
      rej_q     <= rej_d;
      cnt_q     <= cnt_d;
      enable_q  <= enable_d;
      pend_q    <= pend_d;
    end
  end

endmodule

// File: tb/tb_custom_axi_ip_regif.sv
// Scoreboard bench for custom_axi_ip_regif: bus transactions push expected
// responses, which are popped and compared as the DUT returns them.
module tb_custom_axi_ip_regif;
  import custom_axi_ip_pkg::*;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic          s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0]   s_wdata, s_rdata;
  logic [3:0]    s_wstrb;
  logic [1:0]    s_bresp, s_rresp;
  logic          s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0]   ipreg_data, ipreg_data_out;
  logic          enable_in;
  status_e       status_in;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  logic [31:0] model_data_in;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (enable_in) pulse_cnt++;

  custom_axi_ip_regif #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ipreg_data(ipreg_data), .enable_in(enable_in),
    .ipreg_data_out(ipreg_data_out), .status_in(status_in)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input string name, input logic [AW-1:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] resp);
    bit got = 0;
    bit aw_hs, w_hs, b_seen;
    logic [1:0] b_v = 2'b00;
    logic [1:0] e;
    exp_b.push_back(resp);
    s_awaddr = addr; s_awvalid = 1'b1;
    s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
    s_bready = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      aw_hs  = s_awvalid & s_awready;
      w_hs   = s_wvalid & s_wready;
      b_seen = s_bvalid;
      b_v    = s_bresp;
      step();
      if (aw_hs) s_awvalid = 1'b0;
      if (w_hs) s_wvalid = 1'b0;
      if (b_seen) got = 1;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    e = exp_b.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no write response within budget, expected bresp=%0d", name, e);
    end else if (b_v !== e) begin
      errors++;
      $display("FAIL %s: bresp=%0d expected %0d", name, b_v, e);
    end
  endtask

  task automatic axi_read(input string name, input logic [AW-1:0] addr,
                          input logic [31:0] data, input logic [1:0] resp);
    bit got = 0;
    bit ar_hs, r_seen;
    logic [31:0] d_v = '0;
    logic [1:0]  r_v = 2'b00;
    rexp_t e;
    exp_r.push_back('{data: data, resp: resp});
    s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      ar_hs  = s_arvalid & s_arready;
      r_seen = s_rvalid;
      d_v    = s_rdata;
      r_v    = s_rresp;
      step();
      if (ar_hs) s_arvalid = 1'b0;
      if (r_seen) got = 1;
    end
    s_arvalid = 1'b0; s_rready = 1'b0;
    e = exp_r.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no read response within budget, expected rdata=%h", name, e.data);
    end else if (d_v !== e.data || r_v !== e.resp) begin
      errors++;
      $display("FAIL %s: rdata=%h rresp=%0d expected rdata=%h rresp=%0d",
               name, d_v, r_v, e.data, e.resp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, enable_in} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: aw/w/ar_ready=%b%b%b b/r_valid=%b%b en=%b",
               s_awready, s_wready, s_arready, s_bvalid, s_rvalid, enable_in);
    end
    checks++;
    if (ipreg_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data_in: ipreg_data=%h expected 0", ipreg_data);
    end
    rst_n = 1'b1;
    step();
    axi_write("rst_pre_write", 8'h04, 32'h0000_00AA, 4'hF, RESP_OKAY);
    s_awaddr = 8'h04; s_awvalid = 1'b1;
    step();
    s_awvalid = 1'b0;
    checks++;
    if (s_awready !== 1'b0) begin
      errors++;
      $display("FAIL rst_aw_held: awready=%b expected 0", s_awready);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({s_bvalid, s_rvalid, enable_in} !== 3'b000 || ipreg_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_txn: bvalid=%b rvalid=%b en=%b ipreg_data=%h expected all 0",
               s_bvalid, s_rvalid, enable_in, ipreg_data);
    end
    axi_read("rst_readback_zero", 8'h04, 32'h0, RESP_OKAY);
    axi_write("rst_post_write", 8'h04, 32'h0000_0055, 4'hF, RESP_OKAY);
    axi_read("rst_post_read", 8'h04, 32'h0000_0055, RESP_OKAY);
    model_data_in = 32'h0000_0055;
  endtask

  task automatic test_strobe();
    axi_write("strb_lo", 8'h04, 32'h0000_00FF, 4'b0011, RESP_OKAY);
    axi_write("strb_hi", 8'h04, 32'h1234_5678, 4'b1100, RESP_OKAY);
    axi_read("strb_read", 8'h04, 32'h1234_00FF, RESP_OKAY);
    model_data_in = 32'h1234_00FF;
  endtask

  task automatic test_aw_before_w();
    int nb = 0;
    logic [1:0] e;
    exp_b.push_back(RESP_OKAY);
    s_bready = 1'b0;
    s_awaddr = 8'h04; s_awvalid = 1'b1;
    for (int i = 0; i < 10 && !s_awready; i++) step();
    step();
    s_awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (s_awready !== 1'b0 || s_bvalid !== 1'b0) begin
        errors++;
        $display("FAIL awfirst_wait%0d: awready=%b bvalid=%b expected 0 0", i, s_awready, s_bvalid);
      end
      step();
    end
    s_wdata = 32'hCAFE_0001; s_wstrb = 4'hF; s_wvalid = 1'b1;
    for (int i = 0; i < 10 && !s_wready; i++) step();
    step();
    s_wvalid = 1'b0;
    for (int i = 0; i < 10 && !s_bvalid; i++) step();
    e = exp_b.pop_front();
    checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== e) begin
      errors++;
      $display("FAIL awfirst_b: bvalid=%b bresp=%0d expected 1 %0d", s_bvalid, s_bresp, e);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (s_bvalid !== 1'b1 || s_awready !== 1'b0) begin
        errors++;
        $display("FAIL awfirst_hold%0d: bvalid=%b awready=%b expected 1 0", i, s_bvalid, s_awready);
      end
    end
    s_bready = 1'b1;
    if (s_bvalid) nb++;
    step();
    s_bready = 1'b0;
    checks++;
    if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin
      errors++;
      $display("FAIL awfirst_release: bvalid=%b awready=%b expected 0 1", s_bvalid, s_awready);
    end
    for (int i = 0; i < 3; i++) begin
      if (s_bvalid) nb++;
      step();
    end
    checks++;
    if (nb != 1) begin
      errors++;
      $display("FAIL awfirst_count: b responses=%0d expected 1", nb);
    end
    model_data_in = 32'hCAFE_0001;
    axi_read("awfirst_read", 8'h04, model_data_in, RESP_OKAY);
  endtask

  task automatic test_start();
    int p0;
    axi_write("start_data", 8'h04, 32'h0000_0010, 4'hF, RESP_OKAY);
    model_data_in = 32'h0000_0010;
    p0 = pulse_cnt;
    axi_write("start_ctrl", 8'h00, 32'h0000_0001, 4'h1, RESP_OKAY);
    step(); step(); step();
    checks++;
    if (pulse_cnt - p0 != 1 || ipreg_data !== 32'h10) begin
      errors++;
      $display("FAIL start_pulse: pulse cycles=%0d ipreg_data=%h expected 1 00000010",
               pulse_cnt - p0, ipreg_data);
    end
    status_in = BUSY;
    step(); step();
    ipreg_data_out = 32'h0000_0011;
    status_in = DONE;
    step();
    status_in = IDLE;
    step();
    axi_read("start_result", 8'h08, 32'h0000_0011, RESP_OKAY);
    axi_read("start_status", 8'h0C, 32'h0000_0104, RESP_OKAY);
    axi_read("ctrl_reads_zero", 8'h00, 32'h0, RESP_OKAY);
  endtask

  task automatic test_reject();
    int p0;
    status_in = BUSY;
    step();
    p0 = pulse_cnt;
    axi_write("rej_start", 8'h00, 32'h0000_0001, 4'h1, RESP_OKAY);
    step(); step();
    checks++;
    if (pulse_cnt != p0) begin
      errors++;
      $display("FAIL rej_no_pulse: pulse cycles=%0d expected 0", pulse_cnt - p0);
    end
    axi_read("rej_status", 8'h0C, 32'h0000_010D, RESP_OKAY);
    axi_write("rej_clr", 8'h00, 32'h0000_0002, 4'h1, RESP_OKAY);
    axi_read("rej_status_clr", 8'h0C, 32'h0000_0001, RESP_OKAY);
    status_in = IDLE;
    step();
  endtask

  task automatic test_double_start();
    int p0 = pulse_cnt;
    axi_write("dbl_start1", 8'h00, 32'h0000_0001, 4'h1, RESP_OKAY);
    axi_write("dbl_start2", 8'h00, 32'h0000_0001, 4'h1, RESP_OKAY);
    step(); step();
    checks++;
    if (pulse_cnt - p0 != 1) begin
      errors++;
      $display("FAIL dbl_pulse: pulse cycles=%0d expected 1", pulse_cnt - p0);
    end
    axi_read("dbl_status", 8'h0C, 32'h0000_0008, RESP_OKAY);
    status_in = BUSY;
    step();
    status_in = IDLE;
    step();
    axi_write("dbl_clr", 8'h00, 32'h0000_0002, 4'h1, RESP_OKAY);
    axi_read("dbl_status_clr", 8'h0C, 32'h0, RESP_OKAY);
  endtask

  task automatic test_slverr();
    axi_write("err_wr_result", 8'h08, 32'h0000_DEAD, 4'hF, RESP_SLVERR);
    axi_write("err_wr_status", 8'h0C, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR);
    axi_write("err_wr_0x30", 8'h30, 32'h0000_BEEF, 4'hF, RESP_SLVERR);
    axi_write("err_wr_0x14", 8'h14, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR);
    axi_read("err_rd_0x40", 8'h40, 32'h0, RESP_SLVERR);
    axi_read("err_result_kept", 8'h08, 32'h0000_0011, RESP_OKAY);
    axi_read("err_data_in_kept", 8'h04, model_data_in, RESP_OKAY);
    axi_read("err_status_kept", 8'h0C, 32'h0, RESP_OKAY);
  endtask

  task automatic test_wrap();
    ipreg_data_out = 32'h0000_0077;
    status_in = DONE;
    repeat (255) step();
    status_in = IDLE;
    step();
    axi_read("wrap_255", 8'h0C, 32'h0000_FF04, RESP_OKAY);
    axi_read("wrap_result", 8'h08, 32'h0000_0077, RESP_OKAY);
    status_in = DONE;
    step();
    status_in = ERROR;
    step();
    axi_read("wrap_0", 8'h0C, 32'h0000_0007, RESP_OKAY);
    status_in = IDLE;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [3:0]  s;
    for (int i = 0; i < 8; i++) begin
      d = 32'($urandom());
      s = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model_data_in[b*8 +: 8] = d[b*8 +: 8];
      end
      axi_write("b2b_write", 8'h04, d, s, RESP_OKAY);
      axi_read("b2b_read", 8'h04, model_data_in, RESP_OKAY);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    ipreg_data_out = '0;
    status_in = IDLE;
    model_data_in = '0;
    #1;
    test_reset();
    test_strobe();
    test_aw_before_w();
    test_start();
    test_reject();
    test_double_start();
    test_slverr();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/custom_axi_ip_regif.md
Name: custom_axi_ip_regif

Overview:
AXI4-Lite slave register file that drives the register-to-hardware interface of the custom IP core.
- Supplies input data to the core and issues one-cycle start pulses.
- Captures the core's result and status into software-readable registers.
- Sits between the system AXI4-Lite interconnect and the core; it is the bus-facing counterpart of the core's ipreg/enable port group.

Parameters:
ADDR_WIDTH, 8, AXI address width; bits [3:2] select the register, any set bit in [ADDR_WIDTH-1:4] is unmapped
DATA_WIDTH, 32, AXI data width; only 32 is supported

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
s_awaddr  in  ADDR_WIDTH  write address
s_awvalid/s_awready  in/out  1  AW handshake
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes
s_wvalid/s_wready  in/out  1  W handshake
s_bresp  out  2  write response
s_bvalid/s_bready  out/in  1  B handshake
s_araddr  in  ADDR_WIDTH  read address
s_arvalid/s_arready  in/out  1  AR handshake
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid/s_rready  out/in  1  R handshake
ipreg_data  out  32  data to core (equals DATA_IN register)
enable_in  out  1  one-cycle start pulse to core
ipreg_data_out  in  32  result from core
status_in  in  status_e  core state

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - All ready, valid and resp outputs are 0; enable_in=0.
  - DATA_IN, RESULT and STATUS flags/count are 0.
  - Any in-flight transaction is dropped.
- Register map:
  - 0x0 CTRL (write-only, reads 0): bit0 START, bit1 CLR.
  - 0x4 DATA_IN: read/write, honours wstrb per byte.
  - 0x8 RESULT: read-only.
  - 0xC STATUS: read-only. [1:0] = live status_in; [2] DONE sticky; [3] REJ sticky; [15:8] done_count; other bits 0.
- Write path:
  - AW and W are accepted independently; each ready is high while its holding slot is empty and no B is pending.
  - Once both slots are full, the write commits in that cycle and s_bvalid rises on the next cycle.
  - B is held until s_bready; the slots reopen the cycle after the B handshake.
  - Response is OKAY for CTRL and DATA_IN.
  - Response is SLVERR for unmapped addresses or writes to RESULT/STATUS; these have no side effect.
- START (CTRL write with wstrb[0]=1 and wdata[0]=1):
  - If status_in==IDLE: enable_in=1 for exactly the cycle after commit.
  - Otherwise no pulse is issued, REJ is set, and the response is still OKAY.
- CLR (wdata[1]=1 with wstrb[0]=1): clears DONE, REJ and done_count.
  - START and CLR in the same write: CLR is applied first, then the START rules.
- Completion capture:
  - On every cycle with status_in==DONE: RESULT <= ipreg_data_out, DONE <= 1, done_count increments (8-bit, wraps 255->0).
  - A CLR in the same cycle as a capture: the capture wins (DONE=1, count=1, REJ cleared).
- Read path:
  - s_arready is high when no R is pending.
  - On the AR handshake, rdata/rresp are registered from the current register values (pre-update values if a write or capture commits that cycle).
  - s_rvalid rises the next cycle and is held until s_rready.
  - Unmapped reads return rdata=0 with SLVERR.
- Concurrency:
  - Read and write channels are fully independent; no ordering between them.
- Core contract:
  - The block never pulses enable_in twice without observing status_in leave IDLE in between.
  - A second START while a pulse is outstanding counts as rejected.

Decomposition:
- custom_axi_ip_pkg:
  - status_e (2-bit: IDLE=0, BUSY=1, DONE=2, ERROR=3), already shared with the core.
  - Add register offsets (CTRL_OFS, DATA_IN_OFS, RESULT_OFS, STATUS_OFS), STATUS bit-position constants, and AXI resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- Sub-module custom_axi_ip_axil_slv: AXI4-Lite handshake/holding logic exposing a simple wr_en/addr/data/strb and rd_en/addr strobe interface.
- Top level holds the register storage and the core interface.

Test Plan:
- Reset mid-transaction: AW accepted, W pending, rst_ni low for 1 cycle -> all valids 0, DATA_IN=0; a subsequent write behaves normally.
- Write DATA_IN=0x0000_00FF, wstrb=4'b0011, then 0x1234_5678 with wstrb=4'b1100 -> read 0x4 returns 0x1234_00FF with OKAY.
- AW sent 3 cycles before W, with s_bready held low 2 cycles -> exactly one B (OKAY) after W; no new AW accepted until the B handshake.
- DATA_IN=0x10, START with the core idle -> enable_in high for exactly 1 cycle.
  - Core goes BUSY then DONE -> RESULT=0x11, STATUS[2]=1, STATUS[15:8]=1.
- START while status_in==BUSY -> no enable_in pulse, STATUS[3]=1.
  - Then CLR -> STATUS[3:2]=0, count=0.
- Write 0x8 and 0x30, read 0x40 -> SLVERR on both; RESULT unchanged; read returns rdata=0.
- 256 completions -> done_count wraps to 0 while DONE stays 1.
